// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bundle between the raster source, the window
// generator and the Sobel frame buffer.
interface sobel_window_gen_if #(
    parameter int COORD_W = 11
) ();
    logic               frame_start;
    logic               pix_valid;
    logic               pix_ready;
    logic [7:0]         pix_data;
    logic               win_valid;
    logic               win_ready;
    logic [7:0]         ul, uc, ur;
    logic [7:0]         ml, mc, mr;
    logic [7:0]         dl, dc, dr;
    logic [COORD_W-1:0] coordinate_X;
    logic [COORD_W-1:0] coordinate_Y;
    logic               frame_done;

    // Pixel source and window consumer side
    modport master (
        output frame_start, pix_valid, pix_data, win_ready,
        input  pix_ready, win_valid, ul, uc, ur, ml, mc, mr, dl, dc, dr,
               coordinate_X, coordinate_Y, frame_done
    );

    // Window generator side
    modport slave (
        input  frame_start, pix_valid, pix_data, win_ready,
        output pix_ready, win_valid, ul, uc, ur, ml, mc, mr, dl, dc, dr,
               coordinate_X, coordinate_Y, frame_done
    );
endinterface

// File: rtl/sobel_window_gen.sv
// Raster-to-3x3 window generator. Buffers two lines, emits one zero-padded
// neighbourhood per pixel tagged with the centre's row/column.
module sobel_window_gen #(
    parameter int WIDTH   = 768,
    parameter int HEIGHT  = 512,
    parameter int COORD_W = 11
) (
    input  logic              CAMERA_CLK,
    input  logic              HRESETn,
    sobel_window_gen_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(HEIGHT - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

    typedef enum logic [1:0] {
        S_FILL,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] in_row_q, in_row_d, in_col_q, in_col_d;
    logic [COORD_W-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [2:0][7:0]    lcol_q, lcol_d, ccol_q, ccol_d;
    logic [8:0][7:0]    win_q, win_d;
    logic               win_valid_q, win_valid_d;
    logic               frame_done_q, frame_done_d;

    logic [7:0]         lb0_q [WIDTH];
    logic [7:0]         lb1_q [WIDTH];

    logic               slot_free, pix_ready, accept, feed, shift, load, at_last;
    logic [COORD_W-1:0] base_row, base_col;
    logic [CW-1:0]      col_idx;
    logic [7:0]         new_pix, r_top, r_mid, r_bot;
    logic               top_z, bot_z, left_z, right_z;

    // Handshake qualification and the incoming column triple
    always_comb begin
        slot_free = !win_valid_q || bus.win_ready;
        pix_ready = ((state_q == S_FILL) || (state_q == S_STREAM)) && slot_free;
        accept    = pix_ready && bus.pix_valid;
        at_last   = win_valid_q && (cx_q == LAST_ROW) && (cy_q == LAST_COL);
        feed      = (state_q == S_FLUSH) && slot_free && !at_last && !bus.frame_start;
        shift     = accept || feed;
        load      = (accept && (state_q == S_STREAM) && !bus.frame_start) || feed;
        // frame_start re-bases the input counters so a same-cycle pixel lands as k = 0
        base_row  = bus.frame_start ? '0 : in_row_q;
        base_col  = bus.frame_start ? '0 : in_col_q;
        col_idx   = base_col[CW-1:0];
        new_pix   = accept ? bus.pix_data : '0;
        r_top     = lb1_q[col_idx];
        r_mid     = lb0_q[col_idx];
        r_bot     = new_pix;
        top_z     = (out_row_q == '0);
        bot_z     = (out_row_q == LAST_ROW);
        left_z    = (out_col_q == '0);
        right_z   = (out_col_q == LAST_COL);
    end

    // Next-state: counters, column shift, window load, FSM transitions
    always_comb begin
        state_d      = state_q;
        in_row_d     = in_row_q;
        in_col_d     = in_col_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        lcol_d       = lcol_q;
        ccol_d       = ccol_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        frame_done_d = 1'b0;

        if (shift) begin
            lcol_d = ccol_q;
            ccol_d = {r_top, r_mid, r_bot};
            if (base_col == LAST_COL) begin
                in_col_d = '0;
                in_row_d = base_row + ONE;
            end else begin
                in_col_d = base_col + ONE;
                in_row_d = base_row;
            end
        end else if (bus.frame_start) begin
            in_row_d = '0;
            in_col_d = '0;
        end

        if (load) begin
            win_d[8] = (top_z || left_z)  ? '0 : lcol_q[2];
            win_d[7] = top_z              ? '0 : ccol_q[2];
            win_d[6] = (top_z || right_z) ? '0 : r_top;
            win_d[5] = left_z             ? '0 : lcol_q[1];
            win_d[4] = ccol_q[1];
            win_d[3] = right_z            ? '0 : r_mid;
            win_d[2] = (bot_z || left_z)  ? '0 : lcol_q[0];
            win_d[1] = bot_z              ? '0 : ccol_q[0];
            win_d[0] = (bot_z || right_z) ? '0 : r_bot;
            cx_d        = out_row_q;
            cy_d        = out_col_q;
            win_valid_d = 1'b1;
            if (out_col_q == LAST_COL) begin
                out_col_d = '0;
                out_row_d = out_row_q + ONE;
            end else begin
                out_col_d = out_col_q + ONE;
            end
        end else if (bus.win_ready) begin
            win_valid_d = 1'b0;
        end

        unique case (state_q)
            S_FILL: begin
                if (accept && (base_row == ONE) && (base_col == '0))
                    state_d = S_STREAM;
            end
            S_STREAM: begin
                if (accept && (in_row_q == LAST_ROW) && (in_col_q == LAST_COL))
                    state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (at_last && bus.win_ready) begin
                    state_d      = S_DONE;
                    frame_done_d = 1'b1;
                    in_row_d     = '0;
                    in_col_d     = '0;
                    out_row_d    = '0;
                    out_col_d    = '0;
                end
            end
            S_DONE: state_d = S_FILL;
            default: state_d = S_FILL;
        endcase

        if (bus.frame_start) begin
            state_d      = S_FILL;
            out_row_d    = '0;
            out_col_d    = '0;
            win_valid_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge CAMERA_CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= S_FILL;
            in_row_q     <= '0;
            in_col_q     <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            lcol_q       <= '0;
            ccol_q       <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_row_q     <= in_row_d;
            in_col_q     <= in_col_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            lcol_q       <= lcol_d;
            ccol_q       <= ccol_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffers: age the column one line and store the new pixel
    always_ff @(posedge CAMERA_CLK) begin
        if (shift) begin
            lb1_q[col_idx] <= lb0_q[col_idx];
            lb0_q[col_idx] <= new_pix;
        end
    end

    assign bus.pix_ready    = pix_ready;
    assign bus.win_valid    = win_valid_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.coordinate_X = cx_q;
    assign bus.coordinate_Y = cy_q;
    assign bus.ul = win_q[8];
    assign bus.uc = win_q[7];
    assign bus.ur = win_q[6];
    assign bus.ml = win_q[5];
    assign bus.mc = win_q[4];
    assign bus.mr = win_q[3];
    assign bus.dl = win_q[2];
    assign bus.dc = win_q[1];
    assign bus.dr = win_q[0];
endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x3 frame.
module tb_sobel_window_gen;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int CWD = 11;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_total = 0;

    logic [7:0]  frame_pix [N];
    logic [71:0] cap [N];

    typedef struct {
        string       name;
        int          r;
        int          c;
        logic [71:0] exp;
    } vec_t;
    vec_t vecs [4];

    sobel_window_gen_if #(.COORD_W(CWD)) bus ();

    sobel_window_gen #(.WIDTH(W), .HEIGHT(H), .COORD_W(CWD)) dut (
        .CAMERA_CLK (clk),
        .HRESETn    (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Zero-padded 3x3 neighbourhood of (r,c) straight from the frame array
    function automatic logic [71:0] model_win(input int r, input int c);
        logic [71:0] w = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                logic [7:0] v = 8'd0;
                if (r + dy >= 0 && r + dy < H && c + dx >= 0 && c + dx < W)
                    v = frame_pix[(r + dy) * W + (c + dx)];
                w = {w[63:0], v};
            end
        end
        return w;
    endfunction

    function automatic logic [71:0] dut_win();
        return {bus.ul, bus.uc, bus.ur, bus.ml, bus.mc, bus.mr, bus.dl, bus.dc, bus.dr};
    endfunction

    // Drive one frame (or its first n_send pixels) and score every window beat
    task automatic run_frame(input int base, input int rdy_pct, input int n_send,
                             input bit fs_first, input bit full);
        int sent = 0, wcnt = 0, dones = 0, cyc = 0, drain = 0;
        int k5_cyc = -1, first_v = -1, last_v = -1;
        bit stop = 0, prev_stall = 0;
        logic [71:0] prev_win = '0;
        logic [2*CWD-1:0] prev_xy = '0;
        for (int k = 0; k < N; k++) frame_pix[k] = 8'(base + k);
        while (!stop) begin
            @(negedge clk);
            bus.frame_start = fs_first && (cyc == 0);
            bus.pix_valid   = (sent < n_send);
            bus.pix_data    = (sent < N) ? frame_pix[sent] : 8'd0;
            bus.win_ready   = ($urandom_range(0, 99) < rdy_pct);
            #1;
            if (prev_stall) begin
                check("hold_valid", bus.win_valid, 1);
                check("hold_window", dut_win(), prev_win);
                check("hold_coord", {bus.coordinate_X, bus.coordinate_Y}, prev_xy);
            end
            if (bus.win_valid && first_v < 0) first_v = cyc;
            if (bus.win_valid && bus.win_ready) begin
                check("coord_x", bus.coordinate_X, wcnt / W);
                check("coord_y", bus.coordinate_Y, wcnt % W);
                check("window", dut_win(), model_win(wcnt / W, wcnt % W));
                if (full && wcnt < N) cap[wcnt] = dut_win();
                wcnt++;
                last_v = cyc;
            end
            if (bus.frame_done) begin
                dones++;
                done_total++;
                check("done_after_last", wcnt, N);
                check("done_no_valid", bus.win_valid, 0);
                stop = full;
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (sent == 5) k5_cyc = cyc;
                sent++;
            end
            prev_stall = bus.win_valid && !bus.win_ready;
            prev_win   = dut_win();
            prev_xy    = {bus.coordinate_X, bus.coordinate_Y};
            cyc++;
            if (!full && sent == n_send) begin
                drain++;
                if (drain >= 3) stop = 1;
            end
            if (cyc > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout: got %0d windows %0d done pulses after %0d cycles", wcnt, dones, cyc);
                stop = 1;
            end
        end
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        if (full) begin
            check("window_count", wcnt, N);
            check("done_count", dones, 1);
            if (rdy_pct == 100) begin
                check("first_valid_latency", first_v, k5_cyc + 1);
                check("no_bubbles", last_v - first_v, N - 1);
            end
        end else begin
            check("no_done_partial", dones, 0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, bus.win_valid, 0);
        check({tag, "_done"}, bus.frame_done, 0);
        check({tag, "_coord"}, {bus.coordinate_X, bus.coordinate_Y}, 0);
        check({tag, "_window"}, dut_win(), 0);
    endtask

    initial begin
        vecs[0] = '{"win_1_1", 1, 1, {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11}};
        vecs[1] = '{"win_0_0", 0, 0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6}};
        vecs[2] = '{"win_2_3", 2, 3, {8'd7, 8'd8, 8'd0, 8'd11, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[3] = '{"win_1_3", 1, 3, {8'd3, 8'd4, 8'd0, 8'd7, 8'd8, 8'd0, 8'd11, 8'd12, 8'd0}};

        rst_n           = 1'b0;
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.pix_data    = 8'd0;
        bus.win_ready   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_pix_ready", bus.pix_ready, 1);

        // Full-rate frame, pixel k = k+1
        run_frame(1, 100, N, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            check(vecs[i].name, cap[vecs[i].r * W + vecs[i].c], vecs[i].exp);

        // Back-to-back frame with different data
        run_frame(101, 100, N, 1'b0, 1'b1);
        check("two_done_pulses", done_total, 2);

        // Random consumer backpressure
        run_frame(1, 50, N, 1'b0, 1'b1);

        // Abort after 7 pixels, restart with frame_start plus first pixel
        run_frame(31, 100, 7, 1'b0, 1'b0);
        run_frame(1, 100, N, 1'b1, 1'b1);

        // Reset while flushing, then a clean frame
        run_frame(61, 100, N, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.win_ready = 1'b1;
        #1;
        check_zero_outputs("flush_reset");
        repeat (2) begin
            @(negedge clk);
            #1;
            check_zero_outputs("flush_reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(1, 100, N, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
